// File: rtl/debouncer_multi_if.sv
// ---------------------------------------------------------------------------
// debouncer_multi_if
//   Bundles the per-channel data signals of debouncer_multi so that the
//   debouncer and its user share one port.
//
//   noisy_in     : raw contact inputs, one bit per channel (master -> slave)
//   limit        : required stable-sample count, shared by all channels
//                  (master -> slave)
//   debounce_out : filtered level per channel (slave -> master)
//   rise_pulse   : one-cycle pulse on a qualified press (slave -> master)
//   fall_pulse   : one-cycle pulse on a qualified release (slave -> master)
//
//   Modports: master = input source / output consumer, slave = debouncer.
// ---------------------------------------------------------------------------
interface debouncer_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  logic [N_CH-1:0]  noisy_in;
  logic [CNT_W-1:0] limit;
  logic [N_CH-1:0]  debounce_out;
  logic [N_CH-1:0]  rise_pulse;
  logic [N_CH-1:0]  fall_pulse;

  modport master (
    output noisy_in,
    output limit,
    input  debounce_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  noisy_in,
    input  limit,
    output debounce_out,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/debouncer_multi.sv
// ---------------------------------------------------------------------------
// debouncer_multi
//   Multi-channel switch debouncer. Each channel is filtered independently:
//   a level change is accepted only after the new level has been sampled on
//   L+1 consecutive cycles, where L = limit (limit == 0 behaves as L = 1).
//   Accepted changes produce one-cycle rise/fall pulses alongside the
//   filtered level. All outputs are registered.
//
//   Ports:
//     clk     : system clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : debouncer_multi_if.slave (noisy_in, limit in;
//               debounce_out, rise_pulse, fall_pulse out)
//
//   Build option:
//     DEBOUNCER_SYNC_EN : when defined, each noisy_in bit passes through a
//                         2-flop synchroniser first (adds 2 cycles latency).
//                         When undefined, inputs must already be synchronous.
// ---------------------------------------------------------------------------
module debouncer_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  debouncer_multi_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    QUAL_HI = 2'd1,
    HOLD_HI = 2'd2,
    QUAL_LO = 2'd3
  } state_t;

  // Qualification threshold expressed as L-1, with limit == 0 folded to L = 1.
  function automatic logic [CNT_W-1:0] lim_m1(input logic [CNT_W-1:0] lim);
    if (lim == '0) begin
      lim_m1 = '0;
    end else begin
      lim_m1 = lim - CNT_W'(1);
    end
  endfunction

  logic [N_CH-1:0]  s_in;
  logic [CNT_W-1:0] thr;

  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];

  logic [N_CH-1:0]  out_d;
  logic [N_CH-1:0]  rise_d;
  logic [N_CH-1:0]  fall_d;
  logic [N_CH-1:0]  out_q;
  logic [N_CH-1:0]  rise_q;
  logic [N_CH-1:0]  fall_q;

`ifdef DEBOUNCER_SYNC_EN
  logic [N_CH-1:0]  sync_p0;
  logic [N_CH-1:0]  sync_p1;

  // synchroniser stage boundary: pin -> sync_p0 -> sync_p1 -> s_in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.noisy_in;
      sync_p1 <= sync_p0;
    end
  end

  assign s_in = sync_p1;
`else
  assign s_in = bus.noisy_in;
`endif

  // limit is deliberately unregistered so a change takes effect at once.
  assign thr = lim_m1(bus.limit);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rise_d[i]  = 1'b0;
      fall_d[i]  = 1'b0;
      case (state_q[i])
        IDLE_LO: begin
          cnt_d[i] = '0;
          if (s_in[i]) begin
            state_d[i] = QUAL_HI;
          end
        end
        QUAL_HI: begin
          if (!s_in[i]) begin
            state_d[i] = IDLE_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= thr) begin
            // >= so that a lowered limit completes on the next sample.
            state_d[i] = HOLD_HI;
            cnt_d[i]   = '0;
            rise_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HOLD_HI: begin
          cnt_d[i] = '0;
          if (!s_in[i]) begin
            state_d[i] = QUAL_LO;
          end
        end
        QUAL_LO: begin
          if (s_in[i]) begin
            state_d[i] = HOLD_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= thr) begin
            state_d[i] = IDLE_LO;
            cnt_d[i]   = '0;
            fall_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE_LO;
          cnt_d[i]   = '0;
        end
      endcase
      // Output level is registered from the next state so it moves together
      // with the state and the pulses.
      out_d[i] = (state_d[i] == HOLD_HI) || (state_d[i] == QUAL_LO);
    end
  end

  // state / output register boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE_LO;
        cnt_q[i]   <= '0;
      end
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.debounce_out = out_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;

endmodule

// File: tb/tb_debouncer_multi.sv
module tb_debouncer_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
`ifdef DEBOUNCER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk;
  logic reset_n;

  debouncer_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  debouncer_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a channel's output flips once the opposite level has
  // been seen for L+1 consecutive samples.
  logic [N_CH-1:0] m_out, m_rise, m_fall;
  logic [N_CH-1:0] m_pipe0, m_pipe1;
  int              m_run [N_CH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_out   = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_pipe0 = '0;
    m_pipe1 = '0;
    for (int c = 0; c < N_CH; c++) m_run[c] = 0;
  endtask

  // Advance one clock, update the model with the inputs that edge sampled,
  // then compare every output.
  task automatic tick();
    logic [N_CH-1:0] s;
    int              lim;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      model_clear();
    end else begin
      s = (D == 2) ? m_pipe1 : bus.noisy_in;
      m_pipe1 = m_pipe0;
      m_pipe0 = bus.noisy_in;
      lim = (bus.limit == 0) ? 1 : int'(bus.limit);
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < N_CH; c++) begin
        if (s[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] >= lim + 1) begin
            m_out[c] = s[c];
            m_run[c] = 0;
            if (s[c]) m_rise[c] = 1'b1;
            else       m_fall[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    check("debounce_out", 64'(bus.debounce_out), 64'(m_out));
    check("rise_pulse",   64'(bus.rise_pulse),   64'(m_rise));
    check("fall_pulse",   64'(bus.fall_pulse),   64'(m_fall));
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.noisy_in = '0;
    bus.limit    = 16'd4;
    model_clear();

    // Reset state
    for (int r = 0; r < 3; r++) tick();
    check("reset_dout", 64'(bus.debounce_out), 64'd0);
    reset_n = 1'b1;

    // Clean press: ch0 high from cycle 10, limit 4
    for (int r = 0; r <= 20; r++) begin
      if (r >= 10) bus.noisy_in[0] = 1'b1;
      tick();
      if (r + 1 == 14 + D) check("press_before", 64'(bus.debounce_out[0]), 64'd0);
      if (r + 1 == 15 + D) begin
        check("press_dout", 64'(bus.debounce_out[0]), 64'd1);
        check("press_rise", 64'(bus.rise_pulse[0]), 64'd1);
      end
      if (r + 1 == 16 + D) begin
        check("press_rise_end", 64'(bus.rise_pulse[0]), 64'd0);
        check("press_hold", 64'(bus.debounce_out[0]), 64'd1);
      end
    end

    // Glitch: ch1 high for cycles 10..13 only
    for (int r = 0; r <= 25; r++) begin
      bus.noisy_in[1] = (r >= 10 && r <= 13);
      tick();
      check("glitch_dout", 64'(bus.debounce_out[1]), 64'd0);
      check("glitch_rise", 64'(bus.rise_pulse[1]), 64'd0);
    end

    // Release bounce: ch0 low 27-28, high 29, low steady from 30
    for (int r = 0; r <= 40; r++) begin
      bus.noisy_in[0] = (r < 27) || (r == 29);
      tick();
      if (r + 1 == 34 + D) check("rel_before", 64'(bus.debounce_out[0]), 64'd1);
      if (r + 1 == 35 + D) begin
        check("rel_fall", 64'(bus.fall_pulse[0]), 64'd1);
        check("rel_dout", 64'(bus.debounce_out[0]), 64'd0);
      end
      if (r + 1 < 35 + D) check("rel_nofall", 64'(bus.fall_pulse[0]), 64'd0);
    end

    // limit == 0 acts as limit == 1: ch2 high from cycle 5
    bus.limit = '0;
    for (int r = 0; r <= 12; r++) begin
      if (r >= 5) bus.noisy_in[2] = 1'b1;
      tick();
      if (r + 1 == 6 + D) check("lim0_before", 64'(bus.debounce_out[2]), 64'd0);
      if (r + 1 == 7 + D) check("lim0_rise", 64'(bus.rise_pulse[2]), 64'd1);
    end

    // Reset during qualification: limit 8, ch3 high from 10, reset 12..13
    bus.limit = 16'd8;
    for (int r = 0; r <= 30; r++) begin
      if (r >= 10) bus.noisy_in[3] = 1'b1;
      reset_n = !(r == 12 || r == 13);
      tick();
      if (r + 1 < 23 + D) check("rst_norise", 64'(bus.rise_pulse[3]), 64'd0);
      if (r + 1 == 23 + D) check("rst_rise", 64'(bus.rise_pulse[3]), 64'd1);
    end
    reset_n = 1'b1;

    // Randomised staggered traffic on all channels
    for (int r = 0; r < 4000; r++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(3 + 3 * c, 0) == 0) bus.noisy_in[c] = ~bus.noisy_in[c];
      end
      if ($urandom_range(60, 0) == 0) bus.limit = CNT_W'($urandom_range(6, 0));
      reset_n = ($urandom_range(700, 0) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
